// File: rtl/kronecker_restore.sv
// kronecker_restore: queues 2-share Kronecker delta tokens and XORs each one into bit0 of the matching masked byte shares.
// Define KRONECKER_RESTORE_REFRESH_EN to re-mask every token with i_rand as it is written.
module kronecker_restore #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_d_valid,
  output logic        o_d_ready,
  input  logic [1:0]  i_d_in,
  input  logic        i_rand,
  input  logic        i_x_valid,
  output logic        o_x_ready,
  input  logic [15:0] i_x_in,
  output logic        o_y_valid,
  input  logic        i_y_ready,
  output logic [15:0] o_y_out,
  output logic        o_underflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_y_valid, r_underflow;
  logic [15:0]   r_y_out;
  logic          w_full, w_empty, w_push, w_pop;
  logic [1:0]    w_tok, w_head;
`ifdef KRONECKER_RESTORE_REFRESH_EN
  assign w_tok = i_d_in ^ {2{i_rand}};
`else
  logic w_unused;
  assign w_unused = i_rand;
  assign w_tok = i_d_in;
`endif
  assign w_full      = r_cnt == CW'(DEPTH);
  assign w_empty     = r_cnt == '0;
  assign o_d_ready   = !w_full;
  assign o_x_ready   = !w_empty && (!r_y_valid || i_y_ready);
  assign w_push      = i_d_valid && o_d_ready;
  assign w_pop       = i_x_valid && o_x_ready;
  assign w_head      = r_mem[r_rp];
  assign o_y_valid   = r_y_valid;
  assign o_y_out     = r_y_out;
  assign o_underflow = r_underflow;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= w_tok;
  // each token share only ever touches its own share byte
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_y_valid   <= 1'b0;
      r_y_out     <= 16'h0000;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt       <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_y_valid   <= w_pop ? 1'b1 : (i_y_ready ? 1'b0 : r_y_valid);
      if (w_pop) r_y_out <= {i_x_in[15:8] ^ {7'b0, w_head[1]}, i_x_in[7:0] ^ {7'b0, w_head[0]}};
      if (i_x_valid && w_empty) r_underflow <= 1'b1;
    end
endmodule

// File: tb/tb_kronecker_restore.sv
// tb_kronecker_restore: directed checks of token ordering, handshakes, underflow, reset and optional refresh.
module tb_kronecker_restore;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        d_valid = 1'b0, rand_b = 1'b0, x_valid = 1'b0, y_ready = 1'b0;
  logic [1:0]  d_in = 2'b00;
  logic [15:0] x_in = 16'h0000;
  logic        d_ready, x_ready, y_valid, underflow;
  logic [15:0] y_out;
  int checks = 0, failures = 0;

  kronecker_restore #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_d_valid(d_valid), .o_d_ready(d_ready), .i_d_in(d_in), .i_rand(rand_b),
    .i_x_valid(x_valid), .o_x_ready(x_ready), .i_x_in(x_in),
    .o_y_valid(y_valid), .i_y_ready(y_ready), .o_y_out(y_out),
    .o_underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #3;
    chk("rst_y_valid", 16'(y_valid), 16'h0);
    chk("rst_y_out", y_out, 16'h0000);
    chk("rst_d_ready", 16'(d_ready), 16'h1);
    chk("rst_x_ready", 16'(x_ready), 16'h0);
    chk("rst_underflow", 16'(underflow), 16'h0);
    tick();
    rst_n = 1'b1;
    // basic
    d_valid = 1'b1; d_in = 2'b01;
    tick();
    d_valid = 1'b0;
    chk("basic_x_ready", 16'(x_ready), 16'h1);
    x_valid = 1'b1; x_in = 16'hA53C; y_ready = 1'b1;
    tick();
    x_valid = 1'b0;
    chk("basic_y_valid", 16'(y_valid), 16'h1);
    chk("basic_y_out", y_out, 16'hA53D);
    chk("basic_x_ready_empty", 16'(x_ready), 16'h0);
    // order
    d_valid = 1'b1;
    d_in = 2'b10; tick();
    d_in = 2'b00; tick();
    d_in = 2'b11; tick();
    d_valid = 1'b0;
    x_valid = 1'b1; x_in = 16'h0000;
    tick(); chk("order_0", y_out, 16'h0100);
    tick(); chk("order_1", y_out, 16'h0000);
    tick(); chk("order_2", y_out, 16'h0101);
    x_valid = 1'b0;
    chk("order_y_valid", 16'(y_valid), 16'h1);
    tick();
    chk("drain_y_valid", 16'(y_valid), 16'h0);
    // full / stall
    y_ready = 1'b0; d_valid = 1'b1;
    d_in = 2'b01; tick();
    d_in = 2'b10; tick();
    d_in = 2'b11; tick();
    d_in = 2'b00; tick();
    d_valid = 1'b0;
    chk("full_d_ready", 16'(d_ready), 16'h0);
    chk("full_x_ready", 16'(x_ready), 16'h1);
    x_valid = 1'b1; x_in = 16'h1234;
    tick();
    x_valid = 1'b0;
    chk("stall_y_out", y_out, 16'h1235);
    chk("stall_x_ready", 16'(x_ready), 16'h0);
    chk("stall_d_ready", 16'(d_ready), 16'h1);
    y_ready = 1'b1;
    #1;
    chk("unstall_x_ready", 16'(x_ready), 16'h1);
    x_valid = 1'b1; x_in = 16'h0000;
    tick();
    x_valid = 1'b0; y_ready = 1'b0;
    chk("b2b_y_valid", 16'(y_valid), 16'h1);
    chk("b2b_y_out", y_out, 16'h0100);
    // reset mid-run with 3 tokens and a pending result
    d_valid = 1'b1; d_in = 2'b01;
    tick();
    d_valid = 1'b0;
    chk("pre_rst_y_valid", 16'(y_valid), 16'h1);
    chk("pre_rst_d_ready", 16'(d_ready), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_y_valid", 16'(y_valid), 16'h0);
    chk("mid_rst_y_out", y_out, 16'h0000);
    chk("mid_rst_d_ready", 16'(d_ready), 16'h1);
    chk("mid_rst_x_ready", 16'(x_ready), 16'h0);
    #1 rst_n = 1'b1;
    tick();
    // underflow: no token may survive reset
    x_valid = 1'b1; x_in = 16'hFFFF; y_ready = 1'b1;
    #1;
    chk("uf_x_ready", 16'(x_ready), 16'h0);
    tick();
    x_valid = 1'b0;
    chk("uf_set", 16'(underflow), 16'h1);
    chk("uf_no_consume", 16'(y_valid), 16'h0);
    tick(); tick();
    chk("uf_sticky", 16'(underflow), 16'h1);
    // simultaneous push and pop
    d_valid = 1'b1; d_in = 2'b11;
    tick();
    d_in = 2'b10; x_valid = 1'b1; x_in = 16'h0000;
    tick();
    d_valid = 1'b0;
    chk("pp_y_out", y_out, 16'h0101);
    chk("pp_x_ready", 16'(x_ready), 16'h1);
    tick();
    x_valid = 1'b0;
    chk("pp_y_out2", y_out, 16'h0100);
    chk("pp_empty", 16'(x_ready), 16'h0);
    tick();
    // refresh
    d_valid = 1'b1; d_in = 2'b01; rand_b = 1'b1;
    tick();
    d_valid = 1'b0; rand_b = 1'b0;
    x_valid = 1'b1; x_in = 16'h0000;
    tick();
    x_valid = 1'b0;
`ifdef KRONECKER_RESTORE_REFRESH_EN
    chk("refresh_y_out", y_out, 16'h0100);
`else
    chk("refresh_y_out", y_out, 16'h0001);
`endif
    chk("refresh_delta", 16'(y_out[0] ^ y_out[8]), 16'h1);
    chk("final_underflow", 16'(underflow), 16'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/kronecker_restore.md
KRONECKER_RESTORE -- requirements
Module: kronecker_restore

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning delta-token FIFO depth (power of two, 2..16).
REQ-002 clk  input  1  clock, all state updated on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 d_valid  input  1  2-share Kronecker delta token offered.
REQ-005 d_ready  output  1  token accepted when d_valid and d_ready are both high.
REQ-006 d_in  input  2  delta shares; bit0 is share0, bit1 is share1; delta = d_in[0] XOR d_in[1].
REQ-007 rand  input  1  fresh random bit for token refresh.
REQ-008 x_valid  input  1  masked inverter output offered.
REQ-009 x_ready  output  1  inverter output accepted when x_valid and x_ready are both high.
REQ-010 x_in  input  16  two 8-bit Boolean shares; share0 is [7:0], share1 is [15:8].
REQ-011 y_valid  output  1  corrected result held.
REQ-012 y_ready  input  1  consumer accepts the result when y_valid and y_ready are both high.
REQ-013 y_out  output  16  corrected shares, same share layout as x_in.
REQ-014 underflow  output  1  sticky flag, x_valid seen while FIFO empty.

Function
REQ-015 The FIFO SHALL store accepted delta tokens in order; d_ready = not full; no bypass of an empty FIFO.
REQ-016 x_ready SHALL be high iff FIFO non-empty and (y_valid low or y_ready high).
REQ-017 On x accept, the FIFO SHALL pop its head token (t0,t1); on the next cycle y_out[7:0] = x_in[7:0] XOR {7'b0,t0}, y_out[15:8] = x_in[15:8] XOR {7'b0,t1}, and y_valid = 1; latency is 1 cycle.
REQ-018 Shares SHALL never be combined: no logic path SHALL XOR share0 with share1 data, and t0/t1 SHALL each reach the output only through y_out registers.
REQ-019 y_valid SHALL clear on y accept with no new x accept in the same cycle; with both in the same cycle, y_out SHALL load the new result and y_valid SHALL stay 1.
REQ-020 Push and pop in the same cycle SHALL keep the occupancy unchanged. Push SHALL be allowed then only if not full at cycle start.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; occupancy counter width SHALL be clog2(DEPTH)+1; full = (count == DEPTH), empty = (count == 0).
REQ-022 underflow SHALL set when x_valid is high while empty, and SHALL hold until reset; the x data SHALL NOT be consumed.
REQ-023 The unmasked delta value of every token SHALL be preserved through storage.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear: pointers, count, y_valid, y_out (16'h0000), underflow; d_ready and x_ready then read 1 and 0.
REQ-025 Reset mid-operation SHALL discard all stored tokens and any pending result; no token SHALL survive reset.
REQ-026 Release of rst_n SHALL take effect at the first rising clk edge after deassertion; no handshake SHALL complete on that edge's input if rst_n was low before it.

Configuration
REQ-027 Macro KRONECKER_RESTORE_REFRESH_EN defined: each token SHALL be written as (d_in[0] XOR rand, d_in[1] XOR rand).
REQ-028 Macro KRONECKER_RESTORE_REFRESH_EN undefined: tokens SHALL be stored unmodified; rand SHALL be unused.

Verification
REQ-029 Basic: after reset, push d_in=2'b01, then x_in=16'hA53C -> next cycle y_valid=1, y_out=16'hA53D (share0 bit0 flipped).
REQ-030 Order: push 2'b10, 2'b00, 2'b11 (DEPTH=4), three x_in=16'h0000 with y_ready=1 -> y_out 16'h0100, 16'h0000, 16'h0101 in order.
REQ-031 Full/stall: push 4 tokens -> d_ready=0 on 5th cycle; hold y_ready=0 with one result pending -> x_ready=0; raise y_ready -> x_ready=1 same cycle.
REQ-032 Underflow: x_valid=1 with empty FIFO -> x_ready=0, underflow=1 next cycle and stays 1 until reset.
REQ-033 Refresh (macro defined): push d_in=2'b01 with rand=1, x_in=16'h0000 -> y_out=16'h0100; XOR of the two share bit0s = 1.
REQ-034 Reset mid-run: 3 tokens stored, y_valid=1, assert rst_n=0 -> y_valid=0, y_out=16'h0000, d_ready=1, x_ready=0 without a clock edge.
